sram_mem_ctrl: RTL

SRAM_MEM_CTRL -- requirements
Module: sram_mem_ctrl

---
 rtl/sram_mem_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: single-port word SRAM behind a request-level handshake.
// Rev 1.0 -- IDLE/WRITE/READ_WAIT/RELEASE controller with programmable read wait.
`default_nettype none

module sram_mem_ctrl #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cpu_wr_req,
  input  logic                  cpu_rd_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_data_in,
  output logic [DATA_WIDTH-1:0] cpu_data_out,
  output logic                  cpu_data_valid,
  output logic                  ctrl_busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LATENCY);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITE     = 2'd1;
  localparam logic [1:0] READ_WAIT = 2'd2;
  localparam logic [1:0] RELEASE   = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  wr_q;
  logic [CNT_W-1:0]      wait_cnt;
  logic                  read_done;
  logic                  release_exit;

  assign read_done = (state == READ_WAIT) && (wait_cnt == '0);

  // Leave RELEASE only once the request that was just serviced is no longer presented.
  assign release_exit = (!cpu_wr_req && !cpu_rd_req) ||
                        (cpu_addr != addr_q) ||
                        (cpu_wr_req != wr_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_wr_req) begin
          state_next = WRITE;
        end else if (cpu_rd_req) begin
          state_next = READ_WAIT;
        end
      end
      WRITE:     state_next = RELEASE;
      READ_WAIT: if (read_done) state_next = RELEASE;
      RELEASE:   if (release_exit) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    ctrl_busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q         <= '0;
      data_q         <= '0;
      wr_q           <= 1'b0;
      wait_cnt       <= '0;
      cpu_data_out   <= '0;
      cpu_data_valid <= 1'b0;
    end else begin
      cpu_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_wr_req) begin
            addr_q <= cpu_addr;
            data_q <= cpu_data_in;
            wr_q   <= 1'b1;
          end else if (cpu_rd_req) begin
            addr_q   <= cpu_addr;
            wr_q     <= 1'b0;
            wait_cnt <= WAIT_LOAD;
          end
        end
        READ_WAIT: begin
          if (wait_cnt == '0) begin
            cpu_data_out   <= mem[addr_q];
            cpu_data_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Array has no reset so contents survive resetn.
  always_ff @(posedge clk) begin
    if (state == WRITE) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule

`default_nettype wire
